// File: rtl/result_packer_pkg.sv
// Shared types for the result packer: FSM state encoding and default lane count.
package result_packer_pkg;

    localparam int BURST_LEN_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/result_packer_queue.sv
// Circular FIFO of packed words for the result packer; head is read combinationally.
module packer_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW:0] cnt;
    logic do_push;
    logic do_pop;

    assign full    = (cnt == (AW+1)'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    // A full queue still takes a word when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/result_packer.sv
// Writeback packer: serial fp16 results -> addressed BURST_LEN-lane words for the DMA.
// Optional word counter built only when RESULT_PACKER_STATS_EN is defined.
module result_packer
    import result_packer_pkg::*;
#(
    parameter int BURST_LEN = BURST_LEN_DEF,
    parameter int ADDR_W    = 10,
    parameter int Q_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W-1:0]       addr_limit,
    input  logic                    in_en,
    input  logic [15:0]             in_data,
    input  logic                    flush,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [ADDR_W-1:0]       m_addr,
    output logic [16*BURST_LEN-1:0] m_data,
    output logic [BURST_LEN-1:0]    m_mask,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [31:0]             word_count
);

    localparam int LW = $clog2(BURST_LEN);
    localparam int QW = ADDR_W + BURST_LEN + 16*BURST_LEN;

    state_t state, state_nx;
    logic [LW-1:0] lane_ptr;
    logic [16*BURST_LEN-1:0] lanes;
    logic [16*BURST_LEN-1:0] merged;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] limit_q;
    logic [LW:0] fill;
    logic [BURST_LEN-1:0] mask_p;
    logic take, full_word, partial, push, pop, q_push;
    logic q_full, q_empty;
    logic [QW-1:0] head;

    always_comb begin
        take   = (state == PACK) && in_en;
        merged = lanes;
        if (take) merged[lane_ptr*16 +: 16] = in_data;
        fill      = {1'b0, lane_ptr} + (LW+1)'(take);
        full_word = take && (lane_ptr == LW'(BURST_LEN-1));
        // Flush closes out whatever the current word holds, same-cycle sample included.
        partial   = (state == PACK) && flush && !full_word && (fill != '0);
        push      = full_word || partial;
        mask_p    = '0;
        for (int i = 0; i < BURST_LEN; i++) begin
            mask_p[i] = full_word || (i < int'(fill));
        end
    end

    assign pop    = m_valid && m_ready;
    assign q_push = push && !start;

    always_comb begin
        state_nx = state;
        done     = 1'b0;
        unique case (state)
            IDLE:    state_nx = IDLE;
            PACK:    if (flush) state_nx = FLUSH;
            FLUSH: begin
                if (q_empty) begin
                    state_nx = IDLE;
                    done     = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (start) begin
            state_nx = PACK;
            done     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_ptr <= '0;
            lanes    <= '0;
            wr_addr  <= '0;
            base_q   <= '0;
            limit_q  <= '0;
            overflow <= 1'b0;
        end else if (start) begin
            lane_ptr <= '0;
            lanes    <= '0;
            wr_addr  <= base_addr;
            base_q   <= base_addr;
            limit_q  <= addr_limit;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                lane_ptr <= '0;
                lanes    <= '0;
                wr_addr  <= (wr_addr == limit_q) ? base_q : wr_addr + 1'b1;
                if (q_full && !pop) overflow <= 1'b1;
            end else if (take) begin
                lane_ptr <= lane_ptr + 1'b1;
                lanes    <= merged;
            end
        end
    end

    packer_queue #(
        .DEPTH (Q_DEPTH),
        .W     (QW)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .clear (start),
        .push  (q_push),
        .pop   (pop),
        .wdata ({wr_addr, mask_p, merged}),
        .rdata (head),
        .full  (q_full),
        .empty (q_empty)
    );

    // Head storage is not reset, so outputs are forced to zero while empty.
    assign m_valid = !q_empty;
    assign {m_addr, m_mask, m_data} = m_valid ? head : '0;
    assign busy = (state == PACK) || (state == FLUSH);

`ifdef RESULT_PACKER_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              word_count <= '0;
        else if (start)                       word_count <= '0;
        else if (pop && word_count != '1)     word_count <= word_count + 1'b1;
    end
`else
    assign word_count = '0;
`endif

endmodule

// File: tb/tb_result_packer.sv
// Directed self-checking bench for result_packer.
module tb_result_packer;

    localparam int BL = 8;
    localparam int AW = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [AW-1:0]   base_addr = '0;
    logic [AW-1:0]   addr_limit = '0;
    logic            in_en = 1'b0;
    logic [15:0]     in_data = '0;
    logic            flush = 1'b0;
    logic            m_valid;
    logic            m_ready = 1'b0;
    logic [AW-1:0]   m_addr;
    logic [16*BL-1:0] m_data;
    logic [BL-1:0]   m_mask;
    logic            busy;
    logic            done;
    logic            overflow;
    logic [31:0]     word_count;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_pop = 0;
    int done_cyc = 0;
    int done_cnt = 0;

    logic [AW-1:0]    cap_addr [$];
    logic [16*BL-1:0] cap_data [$];
    logic [BL-1:0]    cap_mask [$];

    result_packer #(.BURST_LEN(BL), .ADDR_W(AW), .Q_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .addr_limit (addr_limit),
        .in_en      (in_en),
        .in_data    (in_data),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_addr     (m_addr),
        .m_data     (m_data),
        .m_mask     (m_mask),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (m_valid && m_ready) begin
            cap_addr.push_back(m_addr);
            cap_data.push_back(m_data);
            cap_mask.push_back(m_mask);
            last_pop = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_caps();
        cap_addr.delete();
        cap_data.delete();
        cap_mask.delete();
        done_cnt = 0;
    endtask

    task automatic do_start(input logic [AW-1:0] b, input logic [AW-1:0] l);
        base_addr  = b;
        addr_limit = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic sample(input logic [15:0] d);
        in_en = 1'b1;
        in_data = d;
        tick();
        in_en = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (done_cnt == 0 && n < 40) begin
            tick();
            n++;
        end
        check(tag, 64'(done_cnt != 0), 64'd1);
    endtask

    initial begin
        tick();
        tick();
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_m_addr", 64'(m_addr), 64'd0);
        check("rst_word_count", 64'(word_count), 64'd0);
        rst = 1'b0;
        tick();

        // 1: one full word
        m_ready = 1'b1;
        clear_caps();
        do_start(10'h010, 10'h3FF);
        check("t1_busy", 64'(busy), 64'd1);
        for (int i = 0; i < 8; i++) sample(16'h3C00 + 16'(i));
        repeat (3) tick();
        check("t1_words", 64'(cap_addr.size()), 64'd1);
        if (cap_addr.size() >= 1) begin
            check("t1_addr", 64'(cap_addr[0]), 64'h010);
            check("t1_mask", 64'(cap_mask[0]), 64'hFF);
            check("t1_lane0", 64'(cap_data[0][15:0]), 64'h3C00);
            check("t1_lane7", 64'(cap_data[0][127:112]), 64'h3C07);
        end

        // 2: 11 samples then flush
        clear_caps();
        do_start(10'h010, 10'h3FF);
        for (int i = 0; i < 11; i++) sample(16'h0100 + 16'(i));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_done("t2_done_seen");
        repeat (3) tick();
        check("t2_words", 64'(cap_addr.size()), 64'd2);
        if (cap_addr.size() >= 2) begin
            check("t2_addr0", 64'(cap_addr[0]), 64'h010);
            check("t2_mask0", 64'(cap_mask[0]), 64'hFF);
            check("t2_addr1", 64'(cap_addr[1]), 64'h011);
            check("t2_mask1", 64'(cap_mask[1]), 64'h07);
            check("t2_lane2", 64'(cap_data[1][47:32]), 64'h010A);
            check("t2_hi_lanes", 64'(cap_data[1][127:48] != '0), 64'd0);
        end
        check("t2_done_lat", 64'(done_cyc - last_pop), 64'd1);
        check("t2_done_once", 64'(done_cnt), 64'd1);
        check("t2_idle_busy", 64'(busy), 64'd0);

        // 3: address wrap
        clear_caps();
        do_start(10'h000, 10'h001);
        for (int i = 0; i < 24; i++) sample(16'(i));
        repeat (3) tick();
        check("t3_words", 64'(cap_addr.size()), 64'd3);
        if (cap_addr.size() >= 3) begin
            check("t3_addr0", 64'(cap_addr[0]), 64'h000);
            check("t3_addr1", 64'(cap_addr[1]), 64'h001);
            check("t3_addr2", 64'(cap_addr[2]), 64'h000);
        end

        // 4: overflow with stalled DMA
        clear_caps();
        m_ready = 1'b0;
        do_start(10'h020, 10'h3FF);
        for (int i = 0; i < 40; i++) sample(16'(i));
        tick();
        check("t4_overflow", 64'(overflow), 64'd1);
        check("t4_stall_valid", 64'(m_valid), 64'd1);
        check("t4_stall_addr", 64'(m_addr), 64'h020);
        check("t4_no_pop", 64'(cap_addr.size()), 64'd0);
        m_ready = 1'b1;
        repeat (10) tick();
        check("t4_words", 64'(cap_addr.size()), 64'd4);
        for (int k = 0; k < 4 && k < cap_addr.size(); k++) begin
            check("t4_addr", 64'(cap_addr[k]), 64'(10'h020 + k));
            check("t4_lane0", 64'(cap_data[k][15:0]), 64'(8 * k));
        end
        check("t4_ovf_sticky", 64'(overflow), 64'd1);

        // 5: in_en and flush together at lane_ptr 2
        clear_caps();
        do_start(10'h030, 10'h3FF);
        check("t5_ovf_clr", 64'(overflow), 64'd0);
        sample(16'h000A);
        sample(16'h000B);
        in_en = 1'b1;
        in_data = 16'h000C;
        flush = 1'b1;
        tick();
        in_en = 1'b0;
        flush = 1'b0;
        wait_done("t5_done_seen");
        check("t5_words", 64'(cap_addr.size()), 64'd1);
        if (cap_addr.size() >= 1) begin
            check("t5_addr", 64'(cap_addr[0]), 64'h030);
            check("t5_mask", 64'(cap_mask[0]), 64'h07);
            check("t5_lane2", 64'(cap_data[0][47:32]), 64'h000C);
            check("t5_lane0", 64'(cap_data[0][15:0]), 64'h000A);
        end

        // 6: reset mid-PACK with words queued
        clear_caps();
        m_ready = 1'b0;
        do_start(10'h040, 10'h3FF);
        for (int i = 0; i < 24; i++) sample(16'(i));
        check("t6_queued", 64'(m_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", 64'(m_valid), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_wc", 64'(word_count), 64'd0);
        tick();
        rst = 1'b0;
        m_ready = 1'b1;
        tick();
        do_start(10'h040, 10'h3FF);
        for (int i = 0; i < 16; i++) sample(16'(i));
        repeat (4) tick();
        check("t6_words", 64'(cap_addr.size()), 64'd2);
`ifdef RESULT_PACKER_STATS_EN
        check("t6_word_count", 64'(word_count), 64'd2);
`else
        check("t6_word_count", 64'(word_count), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
